// File: rtl/memshare_alloc_sched_if.sv
// Request and allocation handshake bundle for memshare_alloc_sched.
// The master modport is the requester/downstream side; the slave modport is the sequencer.
interface memshare_alloc_sched_if #(
  parameter int RQST_NUM = 8
);
  logic                rqst_valid_i;
  logic                rqst_ready_o;
  logic [RQST_NUM-1:0] rqst_mask_i;
  logic                alloc_valid_o;
  logic                alloc_ready_i;
  logic                alloc_seq_o;
  logic [RQST_NUM-1:0] alloc_mask_o;

  modport master (
    output rqst_valid_i, rqst_mask_i, alloc_ready_i,
    input  rqst_ready_o, alloc_valid_o, alloc_seq_o, alloc_mask_o
  );

  modport slave (
    input  rqst_valid_i, rqst_mask_i, alloc_ready_i,
    output rqst_ready_o, alloc_valid_o, alloc_seq_o, alloc_mask_o
  );
endinterface

// File: rtl/memshare_alloc_sched.sv
// Allocation sequencer for memShare: classifies a bank-request mask and issues it
// downstream as one or two allocation sequences of at most SHARE_CAP requesters each.
module memshare_alloc_sched #(
  parameter int RQST_NUM  = 8,
  parameter int SHARE_CAP = 4,
  parameter int CNT_W     = 16,
  parameter int SYNC_PIPE = 0
) (
  input  logic                  sys_clk,
  input  logic                  rstn,
  memshare_alloc_sched_if.slave bus,
  input  logic                  pipe_begin_i,
  output logic                  isGtr_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      gtr_cnt_o
);
  localparam int              PC_W = $clog2(RQST_NUM + 1);
  localparam logic [PC_W-1:0] CAP  = PC_W'(SHARE_CAP);

  typedef enum logic [1:0] {IDLE, SHIFT_GEN, SEQ0, SEQ1} state_t;

  state_t              state_q, state_d;
  logic [RQST_NUM-1:0] mask_q, mask_d;
  logic [RQST_NUM-1:0] m0_q, m0_d;
  logic [RQST_NUM-1:0] m1_q, m1_d;
  logic                gtr_q, gtr_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [PC_W-1:0]     pc;
  logic [RQST_NUM-1:0] m0_split;
  logic                gtr_now;
  logic                rqst_ready;

  // Walk the mask from bit 0 upward; the first SHARE_CAP set bits form m0.
  always_comb begin
    pc       = '0;
    m0_split = '0;
    for (int i = 0; i < RQST_NUM; i++) begin
      if (mask_q[i]) begin
        if (pc < CAP) m0_split[i] = 1'b1;
        pc = pc + PC_W'(1);
      end
    end
    gtr_now = (pc > CAP);
  end

  always_comb begin
    state_d           = state_q;
    mask_d            = mask_q;
    m0_d              = m0_q;
    m1_d              = m1_q;
    gtr_d             = gtr_q;
    cnt_d             = cnt_q;
    done_d            = 1'b0;
    isGtr_o           = 1'b0;
    rqst_ready        = 1'b0;
    bus.alloc_valid_o = 1'b0;
    bus.alloc_seq_o   = 1'b0;
    bus.alloc_mask_o  = '0;

    case (state_q)
      IDLE: begin
        rqst_ready = rstn & ((SYNC_PIPE != 0) ? pipe_begin_i : 1'b1);
        if (bus.rqst_valid_i && rqst_ready) begin
          mask_d  = bus.rqst_mask_i;
          state_d = SHIFT_GEN;
        end
      end
      SHIFT_GEN: begin
        isGtr_o = gtr_now;
        m0_d    = m0_split;
        m1_d    = mask_q & ~m0_split;
        gtr_d   = gtr_now;
        if (gtr_now && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        if (pc == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = SEQ0;
        end
      end
      SEQ0: begin
        bus.alloc_valid_o = 1'b1;
        bus.alloc_mask_o  = m0_q;
        if (bus.alloc_ready_i) begin
          if (gtr_q) begin
            state_d = SEQ1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      SEQ1: begin
        bus.alloc_valid_o = 1'b1;
        bus.alloc_seq_o   = 1'b1;
        bus.alloc_mask_o  = m1_q;
        if (bus.alloc_ready_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      mask_q  <= '0;
      m0_q    <= '0;
      m1_q    <= '0;
      gtr_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      m0_q    <= m0_d;
      m1_q    <= m1_d;
      gtr_q   <= gtr_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.rqst_ready_o = rqst_ready;
  assign done_o           = done_q;
  assign busy_o           = (state_q != IDLE);
  assign gtr_cnt_o        = cnt_q;
endmodule
